mmul_mac_ctrl: RTL and testbench

- Sequencer that runs a full M×N×K signed 8-bit matrix multiply on one DSP-based MAC unit.
- Generates read addresses for the input (A) and weight (B) buffers and drives the MAC enable/valid/clear controls.
- Captures each 32-bit dot-product result and writes it to the output (C) buffer.
- Sits between the host start/done interface and the MAC + BRAM datapath of the matrix multiplier.

---
 rtl/mmul_mac_ctrl_pkg.sv | 33 +++
 rtl/mmul_mac_ctrl_idx_gen.sv | 100 ++++++++++
 rtl/mmul_mac_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mmul_mac_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmul_mac_ctrl_pkg.sv
// Shared types and sizing helpers for the matrix-multiply MAC sequencer.
// Holds the FSM state encoding and the result/data widths.
package mmul_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  localparam int MAC_RESULT_W = 32;
  localparam int DATA_W       = 8;

  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Address width needed to reach the largest of the three buffers.
  function automatic int req_aw(
    input int m,
    input int n,
    input int k
  );
    int mx;
    mx = m * k;
    if (k * n > mx) mx = k * n;
    if (m * n > mx) mx = m * n;
    return cw(mx);
  endfunction

endpackage

// File: rtl/mmul_mac_ctrl_idx_gen.sv
// Loop counters i/j/k and strength-reduced base addresses for A, B and C.
// Bases step by K (A rows, B columns) and by 1 (C), so no multipliers.
module mmul_idx_gen
  import mmul_pkg::*;
#(
  parameter int DIM_M = 4,
  parameter int DIM_N = 4,
  parameter int DIM_K = 8,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          k_inc_i,
  input  logic          ij_inc_i,
  output logic          k_first_o,
  output logic          k_last_o,
  output logic          j_last_o,
  output logic          i_last_o,
  output logic [AW-1:0] a_addr_o,
  output logic [AW-1:0] b_addr_o,
  output logic [AW-1:0] c_addr_o
);

  localparam int KW = cw(DIM_K);
  localparam int IW = cw(DIM_M);
  localparam int JW = cw(DIM_N);

  localparam logic [AW-1:0] K_STEP = AW'(DIM_K);

  logic [KW-1:0] k_q, k_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [AW-1:0] a_base_q, a_base_d;
  logic [AW-1:0] b_base_q, b_base_d;
  logic [AW-1:0] c_q, c_d;

  assign k_first_o = (k_q == '0);
  assign k_last_o  = (k_q == KW'(DIM_K - 1));
  assign j_last_o  = (j_q == JW'(DIM_N - 1));
  assign i_last_o  = (i_q == IW'(DIM_M - 1));

  assign a_addr_o = a_base_q + AW'(k_q);
  assign b_addr_o = b_base_q + AW'(k_q);
  assign c_addr_o = c_q;

  always_comb begin
    k_d      = k_q;
    i_d      = i_q;
    j_d      = j_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    c_d      = c_q;
    if (clr_i) begin
      k_d      = '0;
      i_d      = '0;
      j_d      = '0;
      a_base_d = '0;
      b_base_d = '0;
      c_d      = '0;
    end else begin
      if (k_inc_i) begin
        k_d = k_last_o ? '0 : k_q + KW'(1);
      end
      if (ij_inc_i) begin
        c_d = c_q + AW'(1);
        if (j_last_o) begin
          j_d      = '0;
          b_base_d = '0;
          if (!i_last_o) begin
            i_d      = i_q + IW'(1);
            a_base_d = a_base_q + K_STEP;
          end
        end else begin
          j_d      = j_q + JW'(1);
          b_base_d = b_base_q + K_STEP;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_q      <= '0;
    end else begin
      k_q      <= k_d;
      i_q      <= i_d;
      j_q      <= j_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      c_q      <= c_d;
    end
  end

endmodule

// File: rtl/mmul_mac_ctrl.sv
// M x N x K matrix-multiply sequencer driving one MAC and the A/B/C buffers.
// Optional MMUL_MAC_CTRL_PERF_EN adds busy-cycle and stall counters.
module mmul_mac_ctrl
  import mmul_pkg::*;
#(
  parameter int DIM_M     = 4,
  parameter int DIM_N     = 4,
  parameter int DIM_K     = 8,
  parameter int AW        = 8,
  parameter int MAC_LAT   = 3,
  parameter int TO_MARGIN = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [AW-1:0]           a_addr_o,
  output logic [AW-1:0]           b_addr_o,
  output logic                    rd_en_o,
  output logic                    mac_en_o,
  output logic                    mac_clr_o,
  output logic                    mac_valid_o,
  input  logic                    mac_valid_i,
  input  logic [MAC_RESULT_W-1:0] mac_result_i,
  output logic                    c_wr_en_o,
  output logic [AW-1:0]           c_addr_o,
  output logic [MAC_RESULT_W-1:0] c_data_o
`ifdef MMUL_MAC_CTRL_PERF_EN
  ,
  output logic [31:0]             cycle_cnt_o,
  output logic [15:0]             stall_cnt_o
`endif
);

  localparam int TO_LIM = MAC_LAT + TO_MARGIN;
  localparam int WCW    = cw(TO_LIM + 2);

  localparam logic [WCW-1:0] WAIT_END = WCW'(TO_LIM);
  localparam logic [WCW-1:0] STALL_TH = WCW'(MAC_LAT + 1);

  state_e state_q, state_d;

  logic [WCW-1:0]          wait_q, wait_d;
  logic [MAC_RESULT_W-1:0] result_q, result_d;
  logic                    error_q, error_d;
  logic                    en_q, en_d;
  logic                    clr_q, clr_d;
  logic                    vld_q, vld_d;

  logic          start_acc;
  logic          wait_hit;
  logic          k_first;
  logic          k_last;
  logic          j_last;
  logic          i_last;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic [AW-1:0] c_addr;

  assign start_acc = (state_q == S_IDLE) && start_i;
  assign wait_hit  = (wait_q == WAIT_END);

  mmul_idx_gen #(
    .DIM_M (DIM_M),
    .DIM_N (DIM_N),
    .DIM_K (DIM_K),
    .AW    (AW)
  ) u_idx (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (start_acc),
    .k_inc_i   (rd_en_o),
    .ij_inc_i  (c_wr_en_o),
    .k_first_o (k_first),
    .k_last_o  (k_last),
    .j_last_o  (j_last),
    .i_last_o  (i_last),
    .a_addr_o  (a_addr),
    .b_addr_o  (b_addr),
    .c_addr_o  (c_addr)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = S_FEED;
      S_FEED:  if (k_last) state_d = S_WAIT;
      S_WAIT: begin
        if (mac_valid_i)   state_d = S_WRITE;
        else if (wait_hit) state_d = S_DONE;
      end
      S_WRITE: state_d = (j_last && i_last) ? S_DONE : S_FEED;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE);
    rd_en_o     = (state_q == S_FEED);
    c_wr_en_o   = (state_q == S_WRITE);
    mac_en_o    = en_q || (state_q == S_WAIT);
    mac_clr_o   = clr_q;
    mac_valid_o = vld_q;
    error_o     = error_q;
    a_addr_o    = rd_en_o ? a_addr : '0;
    b_addr_o    = rd_en_o ? b_addr : '0;
    c_addr_o    = c_wr_en_o ? c_addr : '0;
    c_data_o    = c_wr_en_o ? result_q : '0;
  end

  // Controls lag the read by one cycle to line up with BRAM data.
  always_comb begin
    en_d     = rd_en_o;
    clr_d    = rd_en_o && k_first;
    vld_d    = rd_en_o && k_last;
    wait_d   = (state_q == S_WAIT) ? wait_q + WCW'(1) : '0;
    result_d = result_q;
    error_d  = error_q;
    if (state_q == S_WAIT && mac_valid_i) result_d = mac_result_i;
    if (start_acc) begin
      error_d = 1'b0;
    end else if (state_q == S_WAIT && !mac_valid_i && wait_hit) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q   <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      en_q     <= 1'b0;
      clr_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      result_q <= result_d;
      error_q  <= error_d;
      en_q     <= en_d;
      clr_q    <= clr_d;
      vld_q    <= vld_d;
    end
  end

`ifdef MMUL_MAC_CTRL_PERF_EN
  logic [31:0] cyc_q, cyc_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    cyc_d   = cyc_q;
    stall_d = stall_q;
    if (start_acc) begin
      cyc_d   = '0;
      stall_d = '0;
    end else begin
      if (busy_o && cyc_q != '1) cyc_d = cyc_q + 32'd1;
      if (state_q == S_WAIT && wait_q >= STALL_TH && stall_q != '1) begin
        stall_d = stall_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      stall_q <= stall_d;
    end
  end

  assign cycle_cnt_o = cyc_q;
  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_mmul_mac_ctrl.sv
// Directed bench for mmul_mac_ctrl: a 2x2x2 instance and a 2x2x8 instance,
// each with a BRAM and 3-cycle MAC behavioural model.
module tb_mmul_mac_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start = 1'b0;
  logic start8 = 1'b0;

  int total = 0;
  int bad = 0;

  // ---------------- DUT 2x2x2 ----------------
  logic        busy, done, err, rd_en, mac_en, mac_clr, mac_vo, mac_vi, c_wr;
  logic [7:0]  a_addr, b_addr, c_addr;
  logic [31:0] mac_res, c_data;
`ifdef MMUL_MAC_CTRL_PERF_EN
  logic [31:0] cyc, cyc8;
  logic [15:0] stall, stall8;
`endif

  mmul_mac_ctrl #(
    .DIM_M(2), .DIM_N(2), .DIM_K(2), .AW(8), .MAC_LAT(3), .TO_MARGIN(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .busy_o(busy), .done_o(done), .error_o(err),
    .a_addr_o(a_addr), .b_addr_o(b_addr), .rd_en_o(rd_en),
    .mac_en_o(mac_en), .mac_clr_o(mac_clr), .mac_valid_o(mac_vo),
    .mac_valid_i(mac_vi), .mac_result_i(mac_res),
    .c_wr_en_o(c_wr), .c_addr_o(c_addr), .c_data_o(c_data)
`ifdef MMUL_MAC_CTRL_PERF_EN
    , .cycle_cnt_o(cyc), .stall_cnt_o(stall)
`endif
  );

  logic signed [7:0]  am [0:255];
  logic signed [7:0]  bm [0:255];
  logic signed [7:0]  ad, bd;
  logic signed [31:0] acc;
  logic signed [31:0] rp [0:2];
  logic [2:0]         vp;
  int                 res_cnt = 0;
  int                 drop_idx = -1;

  always @(posedge clk) begin
    logic signed [31:0] nx;
    if (rd_en) begin
      ad <= am[a_addr];
      bd <= bm[b_addr];
    end
    nx = (mac_clr ? 32'sd0 : acc) + ad * bd;
    if (rst) begin
      vp  <= '0;
      acc <= '0;
    end else begin
      if (mac_en) acc <= nx;
      vp    <= {vp[1:0], mac_vo};
      rp[0] <= nx;
      rp[1] <= rp[0];
      rp[2] <= rp[1];
      if (vp[2]) res_cnt <= res_cnt + 1;
    end
  end
  assign mac_vi  = vp[2] && (res_cnt != drop_idx);
  assign mac_res = rp[2];

  int          done_n = 0, busy_n = 0, wr_n = 0;
  logic [7:0]  wa [0:63];
  logic [31:0] wd [0:63];
  logic        err_at_done = 1'b0;

  always @(negedge clk) begin
    if (done) done_n <= done_n + 1;
    if (done) err_at_done <= err;
    if (busy) busy_n <= busy_n + 1;
    if (c_wr) begin
      wa[wr_n[5:0]] <= c_addr;
      wd[wr_n[5:0]] <= c_data;
      wr_n <= wr_n + 1;
    end
  end

  // ---------------- DUT 2x2x8 ----------------
  logic        busy8, done8, err8, rd_en8, mac_en8, mac_clr8, mac_vo8, mac_vi8, c_wr8;
  logic [7:0]  a_addr8, b_addr8, c_addr8;
  logic [31:0] mac_res8, c_data8;

  mmul_mac_ctrl #(
    .DIM_M(2), .DIM_N(2), .DIM_K(8), .AW(8), .MAC_LAT(3), .TO_MARGIN(4)
  ) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8),
    .busy_o(busy8), .done_o(done8), .error_o(err8),
    .a_addr_o(a_addr8), .b_addr_o(b_addr8), .rd_en_o(rd_en8),
    .mac_en_o(mac_en8), .mac_clr_o(mac_clr8), .mac_valid_o(mac_vo8),
    .mac_valid_i(mac_vi8), .mac_result_i(mac_res8),
    .c_wr_en_o(c_wr8), .c_addr_o(c_addr8), .c_data_o(c_data8)
`ifdef MMUL_MAC_CTRL_PERF_EN
    , .cycle_cnt_o(cyc8), .stall_cnt_o(stall8)
`endif
  );

  logic signed [7:0]  am8 [0:255];
  logic signed [7:0]  bm8 [0:255];
  logic signed [7:0]  ad8, bd8;
  logic signed [31:0] acc8;
  logic signed [31:0] rp8 [0:2];
  logic [2:0]         vp8;

  always @(posedge clk) begin
    logic signed [31:0] nx;
    if (rd_en8) begin
      ad8 <= am8[a_addr8];
      bd8 <= bm8[b_addr8];
    end
    nx = (mac_clr8 ? 32'sd0 : acc8) + ad8 * bd8;
    if (rst) begin
      vp8  <= '0;
      acc8 <= '0;
    end else begin
      if (mac_en8) acc8 <= nx;
      vp8    <= {vp8[1:0], mac_vo8};
      rp8[0] <= nx;
      rp8[1] <= rp8[0];
      rp8[2] <= rp8[1];
    end
  end
  assign mac_vi8  = vp8[2];
  assign mac_res8 = rp8[2];

  int          done8_n = 0, busy8_n = 0, wr8_n = 0, clr8_n = 0, clr8_bad = 0;
  logic [7:0]  wa8 [0:63];
  logic [31:0] wd8 [0:63];
  logic        en8_prev = 1'b0;

  always @(negedge clk) begin
    en8_prev <= mac_en8;
    if (done8) done8_n <= done8_n + 1;
    if (busy8) busy8_n <= busy8_n + 1;
    if (mac_clr8) clr8_n <= clr8_n + 1;
    if (mac_clr8 != (mac_en8 && !en8_prev)) clr8_bad <= clr8_bad + 1;
    if (c_wr8) begin
      wa8[wr8_n[5:0]] <= c_addr8;
      wd8[wr8_n[5:0]] <= c_data8;
      wr8_n <= wr8_n + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit sel8);
    @(negedge clk);
    if (sel8) start8 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start8 = 1'b0;
  endtask

  task automatic wait_done(input bit sel8, input int budget);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (sel8 ? done8 : done) seen = 1'b1;
    end
    check(sel8 ? "done8_seen" : "done_seen", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  int c_exp [4] = '{19, 22, 43, 50};

  task automatic full_job(input string tag);
    int b0, d0, w0;
    b0 = busy_n;
    d0 = done_n;
    w0 = wr_n;
    pulse_start(1'b0);
    wait_done(1'b0, 100);
    check({tag, "_busy"}, 64'(busy_n - b0), 64'd29);
    check({tag, "_done"}, 64'(done_n - d0), 64'd1);
    check({tag, "_nwr"}, 64'(wr_n - w0), 64'd4);
    for (int e = 0; e < 4; e++) begin
      check({tag, "_addr"}, 64'(wa[w0 + e]), 64'(e));
      check({tag, "_data"}, 64'(wd[w0 + e]), 64'(c_exp[e]));
    end
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int b0, d0, w0, c0;

    am[0] = 8'sd1; am[1] = 8'sd2; am[2] = 8'sd3; am[3] = 8'sd4;
    bm[0] = 8'sd5; bm[1] = 8'sd7; bm[2] = 8'sd6; bm[3] = 8'sd8;
    for (int x = 0; x < 16; x++) begin
      am8[x] = -8'sd128;
      bm8[x] = -8'sd128;
    end

    repeat (3) @(negedge clk);
    check("rst_outs", 64'({busy, done, err, rd_en, mac_en, mac_clr, mac_vo,
                           c_wr, a_addr, b_addr, c_addr, c_data}), 64'd0);
    check("rst_outs8", 64'({busy8, done8, err8, rd_en8, mac_en8, c_wr8,
                            c_data8}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic 2x2x2 job
    full_job("job1");
`ifdef MMUL_MAC_CTRL_PERF_EN
    check("perf_cyc", 64'(cyc), 64'd29);
    check("perf_stall", 64'(stall), 64'd0);
`endif

    // K=8 with most negative operands
    b0 = busy8_n; d0 = done8_n; w0 = wr8_n; c0 = clr8_n;
    pulse_start(1'b1);
    wait_done(1'b1, 200);
    check("k8_busy", 64'(busy8_n - b0), 64'd53);
    check("k8_done", 64'(done8_n - d0), 64'd1);
    check("k8_nwr", 64'(wr8_n - w0), 64'd4);
    for (int e = 0; e < 4; e++) begin
      check("k8_addr", 64'(wa8[w0 + e]), 64'(e));
      check("k8_data", 64'(wd8[w0 + e]), 64'd131072);
    end
    check("k8_clr_n", 64'(clr8_n - c0), 64'd4);
    check("k8_clr_align", 64'(clr8_bad), 64'd0);

    // start pulses during a running job are dropped
    b0 = busy_n; d0 = done_n; w0 = wr_n;
    pulse_start(1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, 100);
    repeat (40) @(negedge clk);
    check("restart_done", 64'(done_n - d0), 64'd1);
    check("restart_busy", 64'(busy_n - b0), 64'd29);
    check("restart_nwr", 64'(wr_n - w0), 64'd4);
    check("restart_idle", 64'(busy), 64'd0);

    // reset during the second element's WAIT
    d0 = done_n; w0 = wr_n;
    pulse_start(1'b0);
    repeat (10) @(negedge clk);
    check("mid_nwr", 64'(wr_n - w0), 64'd1);
    check("mid_inwait", 64'({mac_en, rd_en}), 64'b10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_outs", 64'({busy, done, err, rd_en, mac_en, mac_clr,
                               mac_vo, c_wr, a_addr, b_addr, c_addr,
                               c_data}), 64'd0);
    repeat (10) @(negedge clk);
    check("mid_no_done", 64'(done_n - d0), 64'd0);
    full_job("after_rst");

    // suppressed result for element (0,1) -> timeout
    drop_idx = res_cnt + 1;
    b0 = busy_n; d0 = done_n; w0 = wr_n;
    pulse_start(1'b0);
    wait_done(1'b0, 100);
    check("to_done", 64'(done_n - d0), 64'd1);
    check("to_nwr", 64'(wr_n - w0), 64'd1);
    check("to_addr", 64'(wa[w0]), 64'd0);
    check("to_data", 64'(wd[w0]), 64'd19);
    check("to_err_at_done", 64'(err_at_done), 64'd1);
    check("to_err_sticky", 64'(err), 64'd1);
    check("to_busy", 64'(busy_n - b0), 64'd18);
`ifdef MMUL_MAC_CTRL_PERF_EN
    check("to_perf_cyc", 64'(cyc), 64'd18);
    check("to_perf_stall", 64'(stall), 64'd4);
`endif
    drop_idx = -1;
    pulse_start(1'b0);
    check("to_err_clr", 64'(err), 64'd0);
    w0 = wr_n;
    wait_done(1'b0, 100);
    check("post_to_nwr", 64'(wr_n - w0), 64'd4);
    check("post_to_last", 64'(wd[w0 + 3]), 64'd50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
